tdc_fifo_rr_reader: RTL



---
 rtl/tdc_fifo_rr_reader_pkg.sv | 23 ++
 rtl/tdc_fifo_rr_reader_rr_pick.sv | 32 +++
 rtl/tdc_fifo_rr_reader.sv | 82 ++++++++
 3 files changed

// File: rtl/tdc_fifo_rr_reader_pkg.sv
// Shared types and defaults for the TDC FIFO round-robin reader.
package tdc_rr_pkg;

  localparam int N_CH_DEF = 4;
  localparam int DW_DEF   = 48;
  localparam int CH_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Output word layout: channel tag above the timestamp.
  function automatic logic [CH_W_DEF+DW_DEF-1:0] pack_word(
    input logic [CH_W_DEF-1:0] ch,
    input logic [DW_DEF-1:0]   data
  );
    return {ch, data};
  endfunction

endpackage

// File: rtl/tdc_fifo_rr_reader_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant_idx,
  output logic            any
);

  localparam logic [CH_W:0] N_LIM = (CH_W+1)'(N_CH);

  logic [N_CH-1:0] rot;
  logic [CH_W-1:0] off;
  logic [CH_W:0]   sum;

  always_comb begin
    // Rotating the doubled vector puts channel ptr at bit 0.
    rot = N_CH'({req, req} >> ptr);
    off = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (rot[i]) off = CH_W'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    // Explicit wrap so non-power-of-two channel counts map correctly.
    if (sum >= N_LIM) sum = sum - N_LIM;
    grant_idx = sum[CH_W-1:0];
  end

  assign any = |req;

endmodule

// File: rtl/tdc_fifo_rr_reader.sv
// Drains N_CH TDC timestamp FIFOs round-robin onto one tagged valid/ready stream.
module tdc_fifo_rr_reader
  import tdc_rr_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DW    = DW_DEF,
  parameter int CH_W  = $clog2(N_CH),
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      fifo_empty,
  input  logic [N_CH*DW-1:0]   fifo_data,
  output logic [N_CH-1:0]      fifo_rd_en,
  output logic [CH_W+DW-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_out
);

  state_t                    state;
  logic [CH_W-1:0]           rr_ptr;
  logic [CH_W-1:0]           sel;
  logic [CH_W-1:0]           pick_idx;
  logic                      pick_any;
  logic [N_CH-1:0][DW-1:0]   ch_data;

  assign ch_data = fifo_data;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req       (~fifo_empty),
    .ptr       (rr_ptr),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Read pulse depends only on registered state, so it is glitch-free and one-hot.
  assign fifo_rd_en = (state == READ) ? (N_CH'(1) << sel) : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      words_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && pick_any) begin
            sel   <= pick_idx;
            state <= READ;
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          // FIFO output register now holds the word popped during READ.
          out_data  <= {sel, ch_data[sel]};
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            words_out <= words_out + 1'b1;
            rr_ptr    <= (sel == CH_W'(N_CH-1)) ? '0 : sel + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
